// File: rtl/gpio_in_conditioner.sv
// Raw-pin input conditioner for the GPIOIN bus: per-pin synchroniser, optional debounce,
// parity append and sticky change IRQ. Optional: GPIO_IN_PARITY_INJECT_EN adds ERR_INJ.

module gpio_in_lane #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic HCLK,
  input  logic HRESETn,
  input  logic pin,
  input  logic db_en,
  output logic filt,
  output logic pending
);
  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   sync_q;
  logic [CW-1:0]          cnt;

  assign sync_q = sync_r[SYNC_STAGES-1];

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) sync_r <= '0;
    else          sync_r <= {sync_r[SYNC_STAGES-2:0], pin};
  end

  // A new level is accepted only after DEBOUNCE_CYCLES consecutive mismatching edges;
  // any return to the committed level restarts the count.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      filt <= 1'b0;
      cnt  <= '0;
    end else if (!db_en) begin
      filt <= sync_q;
      cnt  <= '0;
    end else if (sync_q == filt) begin
      cnt  <= '0;
    end else if (cnt == CNT_LAST) begin
      filt <= sync_q;
      cnt  <= '0;
    end else begin
      cnt  <= cnt + 1'b1;
    end
  end

  assign pending = (sync_q != filt) || (cnt != '0);
endmodule

module gpio_in_conditioner #(
  parameter int WIDTH           = 16,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic             HCLK,
  input  logic             HRESETn,
  input  logic [WIDTH-1:0] PIN_IN,
  input  logic             DB_EN,
  input  logic             PARITYSEL,
  input  logic             IRQ_CLR,
`ifdef GPIO_IN_PARITY_INJECT_EN
  input  logic             ERR_INJ,
`endif
  output logic [WIDTH:0]   GPIOIN_OUT,
  output logic             CHANGE_IRQ,
  output logic             STABLE
);
  logic [WIDTH-1:0] filt;
  logic [WIDTH-1:0] pending;
  logic [WIDTH-1:0] filt_prev;
  logic             par;

  genvar i;
  generate
    for (i = 0; i < WIDTH; i++) begin : g_lane
      gpio_in_lane #(
        .SYNC_STAGES    (SYNC_STAGES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_lane (
        .HCLK   (HCLK),
        .HRESETn(HRESETn),
        .pin    (PIN_IN[i]),
        .db_en  (DB_EN),
        .filt   (filt[i]),
        .pending(pending[i])
      );
    end
  endgenerate

  // filt_prev lags filt by one edge so the IRQ fires the edge after a commit; set beats clear.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      filt_prev  <= '0;
      CHANGE_IRQ <= 1'b0;
    end else begin
      filt_prev <= filt;
      if (filt != filt_prev) CHANGE_IRQ <= 1'b1;
      else if (IRQ_CLR)      CHANGE_IRQ <= 1'b0;
    end
  end

`ifdef GPIO_IN_PARITY_INJECT_EN
  assign par = (PARITYSEL ? ~^filt : ^filt) ^ ERR_INJ;
`else
  assign par = PARITYSEL ? ~^filt : ^filt;
`endif

  assign GPIOIN_OUT = {par, filt};
  assign STABLE     = ~|pending;
endmodule

// File: tb/tb_gpio_in_conditioner.sv
// Scoreboard bench: a per-edge reference model pushes expected outputs, a monitor pops
// and compares after every edge; directed checks cover the latency/priority corner cases.
module tb_gpio_in_conditioner;
  localparam int W = 16;
  localparam int S = 2;
  localparam int D = 4;

  typedef struct packed {
    logic [W:0] out;
    logic       irq;
    logic       stable;
  } exp_t;

  logic         HCLK = 1'b0;
  logic         HRESETn;
  logic [W-1:0] pin;
  logic         db_en, psel, clr;
  logic [W:0]   gout;
  logic         irq, stable;
`ifdef GPIO_IN_PARITY_INJECT_EN
  logic         err_inj;
`endif

  gpio_in_conditioner #(.WIDTH(W), .SYNC_STAGES(S), .DEBOUNCE_CYCLES(D)) dut (
    .HCLK      (HCLK),
    .HRESETn   (HRESETn),
    .PIN_IN    (pin),
    .DB_EN     (db_en),
    .PARITYSEL (psel),
    .IRQ_CLR   (clr),
`ifdef GPIO_IN_PARITY_INJECT_EN
    .ERR_INJ   (err_inj),
`endif
    .GPIOIN_OUT(gout),
    .CHANGE_IRQ(irq),
    .STABLE    (stable)
  );

  always #5 HCLK = ~HCLK;

  int n_chk  = 0;
  int n_pass = 0;
  exp_t sb[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // Reference model: history of pin words, committed word and mismatch run lengths.
  logic [W-1:0] hist [S];
  logic [W-1:0] mf;
  int           run [W];
  logic         changed_last;
  logic         mirq;

  function automatic logic model_par(input logic [W-1:0] v, input logic odd);
    logic p;
    p = ($countones(v) % 2) == 1;
    return odd ? ~p : p;
  endfunction

  task automatic model_step();
    logic [W-1:0] seen, nf;
    exp_t e;
    bit   quiet;
    if (!HRESETn) begin
      for (int k = 0; k < S; k++) hist[k] = '0;
      for (int b = 0; b < W; b++) run[b] = 0;
      mf = '0; changed_last = 0; mirq = 0;
    end else begin
      seen = hist[S-1];
      nf   = mf;
      for (int b = 0; b < W; b++) begin
        if (!db_en) begin
          run[b] = 0;
          nf[b]  = seen[b];
        end else if (seen[b] != mf[b]) begin
          run[b]++;
          if (run[b] >= D) begin nf[b] = seen[b]; run[b] = 0; end
        end else run[b] = 0;
      end
      if (changed_last) mirq = 1;
      else if (clr)     mirq = 0;
      changed_last = (nf != mf);
      mf = nf;
      for (int k = S-1; k > 0; k--) hist[k] = hist[k-1];
      hist[0] = pin;
    end
    quiet = (hist[S-1] == mf);
    for (int b = 0; b < W; b++) if (run[b] != 0) quiet = 0;
    e.out = {model_par(mf, psel), mf};
`ifdef GPIO_IN_PARITY_INJECT_EN
    e.out[W] = e.out[W] ^ err_inj;
`endif
    e.irq    = mirq;
    e.stable = quiet;
    sb.push_back(e);
  endtask

  initial forever begin
    @(posedge HCLK);
    model_step();
  end

  initial forever begin
    exp_t e;
    @(posedge HCLK);
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("sb_gpioin", 32'(gout),   32'(e.out));
      chk("sb_irq",    32'(irq),    32'(e.irq));
      chk("sb_stable", 32'(stable), 32'(e.stable));
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge HCLK);
  endtask

  initial begin
    HRESETn = 1'b0; pin = '0; db_en = 1'b0; psel = 1'b1; clr = 1'b0;
`ifdef GPIO_IN_PARITY_INJECT_EN
    err_inj = 1'b0;
`endif
    cyc(3);
    chk("rst_out_odd", 32'(gout), 32'h10000);
    chk("rst_irq", 32'(irq), 32'h0);
    chk("rst_stable", 32'(stable), 32'h1);
    psel = 1'b0;
    #1;
    chk("rst_out_even", 32'(gout), 32'h00000);
    HRESETn = 1'b1;
    cyc(3);

    // bypass latency
    pin = 16'h0007;
    cyc(2);
    chk("byp_before_e2", 32'(gout), 32'h00000);
    cyc(1);
    chk("byp_after_e2", 32'(gout), 32'h10007);
    chk("byp_irq_e2", 32'(irq), 32'h0);
    cyc(1);
    chk("byp_irq_e3", 32'(irq), 32'h1);
    clr = 1'b1; cyc(1); clr = 1'b0;
    chk("byp_irq_clr", 32'(irq), 32'h0);

    // debounce back to zero, then glitch rejection
    db_en = 1'b1; pin = '0;
    cyc(8);
    clr = 1'b1; cyc(1); clr = 1'b0;
    cyc(1);
    pin = 16'h0001; cyc(3); pin = '0;
    cyc(10);
    chk("glitch_out", 32'(gout), 32'h00000);
    chk("glitch_irq", 32'(irq), 32'h0);
    chk("glitch_stable", 32'(stable), 32'h1);

    // held level commits at edge 5
    pin = 16'h0001;
    cyc(3);
    chk("db_stable_e2", 32'(stable), 32'h0);
    cyc(2);
    chk("db_stable_e4", 32'(stable), 32'h0);
    chk("db_out_e4", 32'(gout), 32'h00000);
    cyc(1);
    chk("db_out_e5", 32'(gout), 32'h10001);
    chk("db_stable_e5", 32'(stable), 32'h1);
    clr = 1'b1;
    cyc(1);
    chk("irq_set_wins", 32'(irq), 32'h1);
    cyc(1);
    chk("irq_clr_alone", 32'(irq), 32'h0);
    clr = 1'b0;

    // async reset in the middle of a count
    pin = 16'h0009;
    cyc(4);
    HRESETn = 1'b0;
    #1;
    chk("midrst_out", 32'(gout), 32'h00000);
    chk("midrst_irq", 32'(irq), 32'h0);
    chk("midrst_stable", 32'(stable), 32'h1);
    cyc(1);
    HRESETn = 1'b1;
    cyc(5);
    chk("midrst_e4", 32'(gout), 32'h00000);
    cyc(1);
    chk("midrst_e5", 32'(gout), 32'h00009);

`ifdef GPIO_IN_PARITY_INJECT_EN
    pin = 16'h0001; db_en = 1'b0;
    cyc(4);
    err_inj = 1'b1; #1;
    chk("inj_on", 32'(gout), 32'h00001);
    err_inj = 1'b0; #1;
    chk("inj_off", 32'(gout), 32'h10001);
`endif

    // randomized phase
    for (int c = 0; c < 3000; c++) begin
      @(negedge HCLK);
      if ($urandom_range(0, 5) == 0)  pin = pin ^ (W'(1) << $urandom_range(0, W-1));
      if ($urandom_range(0, 39) == 0) pin = W'($urandom);
      if ($urandom_range(0, 99) == 0) db_en = ~db_en;
      if ($urandom_range(0, 7) == 0)  psel = ~psel;
      clr = ($urandom_range(0, 9) == 0);
`ifdef GPIO_IN_PARITY_INJECT_EN
      err_inj = ($urandom_range(0, 15) == 0);
`endif
      if (!HRESETn)                          HRESETn = 1'b1;
      else if ($urandom_range(0, 299) == 0)  HRESETn = 1'b0;
    end
    HRESETn = 1'b1;
    cyc(3);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
